// File: rtl/rpsc_interlock_bank_pkg.sv
// rpsc_pkg: shared types and constants for the RPSC interlock bank.
package rpsc_pkg;

   // Bank sequencing state, also exported on o_state for debug.
   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_ARMED   = 2'd1,
      ST_TRIPPED = 2'd2
   } rpsc_ilk_state_t;

   // Active levels of the lamp-test and fault-clear request inputs.
   localparam logic LAMP_TEST_ACTIVE = 1'b1;
   localparam logic CLR_ACTIVE       = 1'b1;

endpackage : rpsc_pkg

// File: rtl/rpsc_interlock_bank_debounce.sv
// rpsc_debounce: one interlock channel -- synchroniser, polarity
// normalisation and debounce. Output db_o is 1 while the channel is in fault.
module rpsc_debounce #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_CYC = 8,
   parameter logic        FAULT_POL    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic db_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   flt_n;
   logic                   db_q, db_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Synchroniser chain; it resets to the channel's idle input level so a
   // freshly reset channel reads healthy whatever its polarity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= {SYNC_STAGES{FAULT_POL}};
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
   end

   assign flt_n = sync_q[SYNC_STAGES-1] ^ FAULT_POL;

   // Count consecutive disagreeing cycles; commit the new level on the last one.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (flt_n != db_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) db_d  = flt_n;
         else                                   cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounced level and run counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o = db_q;

endmodule : rpsc_debounce

// File: rtl/rpsc_interlock_bank.sv
// rpsc_interlock_bank: N-channel interlock front end -- per-channel debounce,
// fault latches, first-fault capture, bank permit FSM, trip counter, lamps.
// Optional feature macro: RPSC_FIRST_FAULT_BLINK_EN (blink the first-fault lamp).
module rpsc_interlock_bank
   import rpsc_pkg::*;
#(
   parameter int unsigned     N_CH         = 16,
   parameter int unsigned     SYNC_STAGES  = 2,
   parameter int unsigned     DEBOUNCE_CYC = 8,
   parameter logic [N_CH-1:0] FAULT_POL    = '0,
   parameter int unsigned     CNT_W        = 8,
   parameter int unsigned     BLINK_DIV    = 25000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         i_raw,
   input  logic [N_CH-1:0]         i_mask,
   input  logic                    i_clr,
   input  logic                    i_la_test,
   output logic [N_CH-1:0]         o_la,
   output logic                    o_permit,
   output logic                    o_ff_valid,
   output logic [$clog2(N_CH)-1:0] o_ff_idx,
   output logic [CNT_W-1:0]        o_trip_count,
   output logic                    o_clr_reject,
   output logic [1:0]              o_state
);

   localparam int unsigned IDX_W       = $clog2(N_CH);
   localparam int unsigned STARTUP_CYC = SYNC_STAGES + DEBOUNCE_CYC;
   localparam int unsigned SU_W        = $clog2(STARTUP_CYC + 1);

   rpsc_ilk_state_t  state_q, state_d;
   logic [N_CH-1:0]  db, act;
   logic             any_act;
   logic [IDX_W-1:0] first_idx;
   logic [N_CH-1:0]  latched_q, latched_d;
   logic             ff_valid_q, ff_valid_d;
   logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
   logic [CNT_W-1:0] trip_cnt_q, trip_cnt_d;
   logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
   logic [N_CH-1:0]  la_q, la_d;
   logic             clr_rej_q;
   logic             capture, trip_evt, clr_ok, clr_rej;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      rpsc_debounce #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .FAULT_POL    (FAULT_POL[gi])
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw_i (i_raw[gi]),
         .db_o  (db[gi])
      );
   end

   assign act     = db & ~i_mask;
   assign any_act = |act;

   // Priority encoder: lowest-numbered active channel wins.
   always_comb begin
      first_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (act[i]) first_idx = IDX_W'(i);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_STARTUP;
      else       state_q <= state_d;
   end

   // FSM next state; STARTUP waits until a fault present at release could be debounced.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_STARTUP: if (su_cnt_q == SU_W'(STARTUP_CYC)) state_d = any_act ? ST_TRIPPED : ST_ARMED;
         ST_ARMED:   if (any_act) state_d = ST_TRIPPED;
         ST_TRIPPED: if ((i_clr == CLR_ACTIVE) && !any_act) state_d = ST_ARMED;
         default:    state_d = ST_STARTUP;
      endcase
   end

   // FSM outputs.
   always_comb begin
      o_permit = (state_q == ST_ARMED);
      o_state  = state_q;
   end

   // A trip straight out of STARTUP records the first fault but is not an
   // ARMED->TRIPPED transition, so only trip_evt advances the counter.
   assign trip_evt = (state_q == ST_ARMED) && any_act;
   assign capture  = trip_evt || ((state_q == ST_STARTUP) && (state_d == ST_TRIPPED));
   assign clr_ok   = (state_q == ST_TRIPPED) && (i_clr == CLR_ACTIVE) && !any_act;
   assign clr_rej  = (state_q == ST_TRIPPED) && (i_clr == CLR_ACTIVE) && any_act;

   // Next values of latches, first-fault record, trip and startup counters.
   always_comb begin
      latched_d  = latched_q | act;
      ff_valid_d = ff_valid_q;
      ff_idx_d   = ff_idx_q;
      trip_cnt_d = trip_cnt_q;
      su_cnt_d   = su_cnt_q;
      if ((state_q == ST_STARTUP) && (su_cnt_q != SU_W'(STARTUP_CYC))) su_cnt_d = su_cnt_q + 1'b1;
      if (capture) begin
         ff_valid_d = 1'b1;
         ff_idx_d   = first_idx;
      end
      if (trip_evt && (trip_cnt_q != '1)) trip_cnt_d = trip_cnt_q + 1'b1;
      if (clr_ok) begin
         latched_d  = '0;
         ff_valid_d = 1'b0;
         ff_idx_d   = '0;
      end
   end

`ifdef RPSC_FIRST_FAULT_BLINK_EN
   localparam int unsigned BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BL_W-1:0] blink_cnt_q;
   logic            blink_on_q;

   // Blink timebase; restarts lit on every first-fault capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (capture) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         blink_on_q  <= ~blink_on_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end
`endif

   // Lamp pattern: latched faults plus live debounced state; lamp test overrides all.
   always_comb begin
      la_d = latched_d | db;
`ifdef RPSC_FIRST_FAULT_BLINK_EN
      if (ff_valid_q) la_d[ff_idx_q] = blink_on_q;
`endif
      if (i_la_test == LAMP_TEST_ACTIVE) la_d = '1;
   end

   // Bank registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latched_q  <= '0;
         ff_valid_q <= 1'b0;
         ff_idx_q   <= '0;
         trip_cnt_q <= '0;
         su_cnt_q   <= '0;
         la_q       <= '0;
         clr_rej_q  <= 1'b0;
      end else begin
         latched_q  <= latched_d;
         ff_valid_q <= ff_valid_d;
         ff_idx_q   <= ff_idx_d;
         trip_cnt_q <= trip_cnt_d;
         su_cnt_q   <= su_cnt_d;
         la_q       <= la_d;
         clr_rej_q  <= clr_rej;
      end
   end

   assign o_la         = la_q;
   assign o_ff_valid   = ff_valid_q;
   assign o_ff_idx     = ff_idx_q;
   assign o_trip_count = trip_cnt_q;
   assign o_clr_reject = clr_rej_q;

endmodule : rpsc_interlock_bank

// File: tb/tb_rpsc_interlock_bank.sv
// Testbench for rpsc_interlock_bank: hand-computed vector table, directed
// corner sequences and randomized traffic against a cycle reference model.
module tb_rpsc_interlock_bank;

   localparam int         N   = 8;
   localparam int         SS  = 2;
   localparam int         DB  = 4;
   localparam logic [7:0] POL = 8'h81;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] i_raw = POL;
   logic [7:0] i_mask = 8'h00;
   logic       i_clr = 1'b0;
   logic       i_la_test = 1'b0;
   logic [7:0] o_la;
   logic       o_permit, o_ff_valid, o_clr_reject;
   logic [2:0] o_ff_idx;
   logic [7:0] o_trip_count;
   logic [1:0] o_state;

   rpsc_interlock_bank #(
      .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB), .FAULT_POL(POL), .CNT_W(8), .BLINK_DIV(5)
   ) dut (
      .clk(clk), .reset(reset), .i_raw(i_raw), .i_mask(i_mask), .i_clr(i_clr),
      .i_la_test(i_la_test), .o_la(o_la), .o_permit(o_permit), .o_ff_valid(o_ff_valid),
      .o_ff_idx(o_ff_idx), .o_trip_count(o_trip_count), .o_clr_reject(o_clr_reject),
      .o_state(o_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   logic [7:0] m_pipe[$];
   int         m_run[N];
   logic [7:0] m_db, m_latched, m_la;
   int         m_since, m_state, m_idx, m_cnt;
   logic       m_ffv, m_rej;

   task automatic model_reset();
      m_pipe.delete();
      for (int k = 0; k < SS; k++) m_pipe.push_back(8'h00);
      for (int k = 0; k < N; k++) m_run[k] = 0;
      m_db = 0; m_latched = 0; m_la = 0; m_since = 0; m_state = 0;
      m_idx = 0; m_cnt = 0; m_ffv = 0; m_rej = 0;
   endtask

   // One clock edge of the bank as described behaviourally: inputs arrive SS
   // edges late, need DB consecutive disagreeing cycles, then drive the FSM.
   task automatic model_step(input logic [7:0] flt, input logic [7:0] msk, input logic clr, input logic lt);
      logic [7:0] seen, act, db_old, lat_new;
      int first;
      seen = m_pipe.pop_front();
      m_pipe.push_back(flt);
      db_old = m_db;
      act = db_old & ~msk;
      first = -1;
      for (int k = 0; k < N; k++) if (act[k] && first < 0) first = k;
      m_rej = 0;
      lat_new = m_latched | act;
      case (m_state)
         0: if (m_since == SS + DB) begin
               if (act != 0) begin m_state = 2; m_ffv = 1; m_idx = first; end
               else m_state = 1;
            end else m_since++;
         1: if (act != 0) begin
               m_state = 2; m_ffv = 1; m_idx = first;
               if (m_cnt < 255) m_cnt++;
            end
         default: if (clr) begin
               if (act == 0) begin lat_new = 0; m_ffv = 0; m_idx = 0; m_state = 1; end
               else m_rej = 1;
            end
      endcase
      m_latched = lat_new;
      m_la = lt ? 8'hFF : (lat_new | db_old);
      for (int k = 0; k < N; k++) begin
         if (seen[k] != db_old[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin m_db[k] = seen[k]; m_run[k] = 0; end
         end else m_run[k] = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_model();
      chk("m_permit", 32'(o_permit), 32'(m_state == 1));
      chk("m_state",  32'(o_state), 32'(m_state));
      chk("m_la",     32'(o_la), 32'(m_la));
      chk("m_ffv",    32'(o_ff_valid), 32'(m_ffv));
      chk("m_ffidx",  32'(o_ff_idx), 32'(m_idx));
      chk("m_cnt",    32'(o_trip_count), 32'(m_cnt));
      chk("m_rej",    32'(o_clr_reject), 32'(m_rej));
   endtask

   logic [7:0] cur_flt = 0;
   logic [7:0] cur_msk = 0;

   // One cycle: called at a negedge, drives inputs, steps the model at the
   // posedge, compares at the following negedge.
   task automatic cyc(input logic [7:0] flt, input logic [7:0] msk, input logic clr, input logic lt);
      i_raw = flt ^ POL; i_mask = msk; i_clr = clr; i_la_test = lt;
      @(posedge clk);
      model_step(flt, msk, clr, lt);
      @(negedge clk);
      cmp_model();
      $display("cyc t=%0t flt=%h msk=%h clr=%0d lt=%0d -> st=%0d permit=%0d la=%h ffv=%0d idx=%0d cnt=%0d rej=%0d",
               $time, flt, msk, clr, lt, o_state, o_permit, o_la, o_ff_valid, o_ff_idx, o_trip_count, o_clr_reject);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(cur_flt, cur_msk, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_raw = POL; i_mask = 0; i_clr = 0; i_la_test = 0;
      cur_flt = 0; cur_msk = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] flt;
      logic [7:0] msk;
      logic       clr;
      logic       lt;
      logic       permit;
      logic [1:0] st;
      logic [7:0] la;
      logic       ffv;
      logic [2:0] idx;
      logic [7:0] cnt;
      logic       rej;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [7:0] flt, input logic permit, input logic [1:0] st,
                               input logic [7:0] la, input logic ffv, input logic [2:0] idx,
                               input logic [7:0] cnt);
      vec_t v;
      v.flt = flt; v.msk = 8'h00; v.clr = 1'b0; v.lt = 1'b0;
      v.permit = permit; v.st = st; v.la = la; v.ffv = ffv; v.idx = idx; v.cnt = cnt; v.rej = 1'b0;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Edges 1..6 after release: STARTUP, 7: ARMED.
      for (int k = 0; k < 6; k++) tbl.push_back(mk(8'h00, 0, 2'd0, 8'h00, 0, 3'd0, 8'd0));
      tbl.push_back(mk(8'h00, 1, 2'd1, 8'h00, 0, 3'd0, 8'd0));
      // ch3 glitch of 3 cycles, then quiet: never trips.
      for (int k = 0; k < 3; k++) tbl.push_back(mk(8'h08, 1, 2'd1, 8'h00, 0, 3'd0, 8'd0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(8'h00, 1, 2'd1, 8'h00, 0, 3'd0, 8'd0));
      // ch3 held: still armed for 6 edges, tripped on the 7th.
      for (int k = 0; k < 6; k++) tbl.push_back(mk(8'h08, 1, 2'd1, 8'h00, 0, 3'd0, 8'd0));
      tbl.push_back(mk(8'h08, 0, 2'd2, 8'h08, 1, 3'd3, 8'd1));

      // Test 1: reset state.
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_permit", 32'(o_permit), 32'd0);
      chk("rst_la", 32'(o_la), 32'd0);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_cnt", 32'(o_trip_count), 32'd0);
      reset = 1'b0;

      // Tests 1-2 from the table.
      for (int r = 0; r < tbl.size(); r++) begin
         cyc(tbl[r].flt, tbl[r].msk, tbl[r].clr, tbl[r].lt);
         chk($sformatf("tbl%0d_permit", r), 32'(o_permit), 32'(tbl[r].permit));
         chk($sformatf("tbl%0d_state", r), 32'(o_state), 32'(tbl[r].st));
         chk($sformatf("tbl%0d_la", r), 32'(o_la), 32'(tbl[r].la));
         chk($sformatf("tbl%0d_ffv", r), 32'(o_ff_valid), 32'(tbl[r].ffv));
         chk($sformatf("tbl%0d_idx", r), 32'(o_ff_idx), 32'(tbl[r].idx));
         chk($sformatf("tbl%0d_cnt", r), 32'(o_trip_count), 32'(tbl[r].cnt));
         chk($sformatf("tbl%0d_rej", r), 32'(o_clr_reject), 32'(tbl[r].rej));
      end
      cur_flt = 8'h08;

      // Clear ch3, re-arm.
      cur_flt = 0; idle(7);
      cyc(0, 0, 1, 0);
      chk("rearm1_state", 32'(o_state), 32'd1);

      // Test 3: simultaneous ch5+ch2, then ch7.
      cur_flt = 8'h24; idle(7);
      chk("t3_state", 32'(o_state), 32'd2);
      chk("t3_idx", 32'(o_ff_idx), 32'd2);
      chk("t3_la", 32'(o_la), 32'h24);
      chk("t3_cnt", 32'(o_trip_count), 32'd2);
      cur_flt = 8'hA4; idle(7);
      chk("t3_idx_frozen", 32'(o_ff_idx), 32'd2);
      chk("t3_la_ch7", 32'(o_la), 32'hA4);

      // Test 4: clear refused while ch2 faulted, accepted once healthy.
      cur_flt = 8'h04; idle(7);
      cyc(8'h04, 0, 1, 0);
      chk("t4_rej_pulse", 32'(o_clr_reject), 32'd1);
      chk("t4_stay", 32'(o_state), 32'd2);
      idle(1);
      chk("t4_rej_end", 32'(o_clr_reject), 32'd0);
      cur_flt = 0; idle(7);
      cyc(0, 0, 1, 0);
      chk("t4_armed", 32'(o_state), 32'd1);
      chk("t4_permit", 32'(o_permit), 32'd1);
      chk("t4_ffv", 32'(o_ff_valid), 32'd0);
      chk("t4_la", 32'(o_la), 32'd0);

      // Test 5: masked channel lights lamp only; lamp test in TRIPPED.
      cur_msk = 8'h10; cur_flt = 8'h10; idle(8);
      chk("t5_la_masked", 32'(o_la), 32'h10);
      chk("t5_permit_masked", 32'(o_permit), 32'd1);
      cur_flt = 8'h12; idle(7);
      chk("t5_state", 32'(o_state), 32'd2);
      chk("t5_idx", 32'(o_ff_idx), 32'd1);
      chk("t5_la", 32'(o_la), 32'h12);
      cyc(8'h12, 8'h10, 0, 1);
      chk("t5_lamptest", 32'(o_la), 32'hFF);
      chk("t5_lt_permit", 32'(o_permit), 32'd0);
      idle(1);
      chk("t5_lt_off", 32'(o_la), 32'h12);

      // Test 6: asynchronous reset mid-TRIPPED.
      reset = 1'b1;
      #1;
      chk("t6_async_la", 32'(o_la), 32'd0);
      chk("t6_async_state", 32'(o_state), 32'd0);
      chk("t6_async_ffv", 32'(o_ff_valid), 32'd0);
      chk("t6_async_cnt", 32'(o_trip_count), 32'd0);
      @(negedge clk);
      do_reset();
      idle(7);
      chk("t6_armed", 32'(o_state), 32'd1);

      // Trip counter saturation.
      for (int k = 0; k < 256; k++) begin
         cur_flt = 8'h01; idle(7);
         cur_flt = 8'h00; idle(7);
         cyc(0, 0, 1, 0);
         if (k == 254) chk("t6_cnt255", 32'(o_trip_count), 32'd255);
      end
      chk("t6_cnt_sat", 32'(o_trip_count), 32'd255);

      // Randomized traffic against the model.
      do_reset();
      idle(7);
      for (int k = 0; k < 800; k++) begin
         logic [7:0] f;
         if ($urandom_range(0, 5) == 0) cur_flt = cur_flt ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 40) == 0) cur_msk = 8'($urandom);
         f = cur_flt;
         if ($urandom_range(0, 9) == 0) f = f ^ (8'h01 << $urandom_range(0, 7));
         cyc(f, cur_msk, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rpsc_interlock_bank
